// File: rtl/pulse_interval_decoder.sv
// Measures the spacing, in clock cycles, between rising edges of a comparator
// pulse stream and hands each interval to a consumer over a valid/ready slot.
module pulse_interval_decoder #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             counter_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             comp_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val,
    output logic             val_valid,
    output logic             overflow,
    output logic             drop_err,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_comp_q;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    logic [WIDTH-1:0] r_val;
    logic             r_val_valid;
    logic             r_overflow;
    logic             r_drop_err;

    logic             w_edge;
    logic             w_result;
    logic             w_result_ovf;
    logic             w_xfer;
    logic             w_load;
    logic             w_drop;

    // comp_q tracks comp_in even while disabled, so a level held across en 0->1 is not an edge
    always_ff @(posedge counter_clk) begin
        if (reset) begin
            r_comp_q <= 1'b0;
        end else begin
            r_comp_q <= comp_in;
        end
    end

    assign w_edge = en & comp_in & ~r_comp_q;

    // FSM state register together with the interval counter
    always_ff @(posedge counter_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                COUNT: begin
                    w_state_nxt = COUNT;
                    if (w_edge) begin
                        w_cnt_nxt = CNT_ONE;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Result generation and output-slot arbitration
    always_comb begin
        w_result     = en & (r_state == COUNT) & w_edge;
        w_result_ovf = (r_cnt == CNT_MAX);
        w_xfer       = r_val_valid & out_ready;
        w_load       = w_result & (~r_val_valid | out_ready);
        w_drop       = w_result & r_val_valid & ~out_ready;
    end

    always_ff @(posedge counter_clk) begin
        if (reset) begin
            r_val       <= '0;
            r_val_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_val       <= r_cnt;
                r_overflow  <= w_result_ovf;
                r_val_valid <= 1'b1;
            end else if (w_xfer) begin
                r_val_valid <= 1'b0;
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Output decode
    always_comb begin
        busy      = (r_state == COUNT);
        val       = r_val;
        val_valid = r_val_valid;
        overflow  = r_overflow;
        drop_err  = r_drop_err;
    end

endmodule

// File: tb/tb_pulse_interval_decoder.sv
// Directed and randomized checks of pulse_interval_decoder against an
// interval-arithmetic reference model (edge timestamps, single result slot).
module tb_pulse_interval_decoder;

    localparam int W   = 7;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         comp_in = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] val;
    logic         val_valid;
    logic         overflow;
    logic         drop_err;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: time of the last accepted edge plus one result slot
    int m_cyc   = 0;
    bit m_meas  = 0;
    int m_start = 0;
    bit m_prev  = 0;
    bit m_valid = 0;
    int m_val   = 0;
    bit m_ovf   = 0;
    bit m_drop  = 0;

    int valid_seen;
    int last_val;

    always #5 clk = ~clk;

    pulse_interval_decoder #(.WIDTH(W)) dut (
        .counter_clk (clk),
        .reset       (reset),
        .en          (en),
        .comp_in     (comp_in),
        .out_ready   (out_ready),
        .val         (val),
        .val_valid   (val_valid),
        .overflow    (overflow),
        .drop_err    (drop_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit c, input bit o);
        bit edge_seen;
        bit produced;
        int res;
        produced = 0;
        res      = 0;
        if (r) begin
            m_meas  = 0;
            m_prev  = 0;
            m_valid = 0;
            m_val   = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            edge_seen = e && c && !m_prev;
            if (!e) begin
                m_meas = 0;
            end else if (edge_seen) begin
                if (m_meas) begin
                    produced = 1;
                    res = m_cyc - m_start;
                    if (res > MAX) res = MAX;
                end
                m_meas  = 1;
                m_start = m_cyc;
            end
            if (produced) begin
                if (!m_valid || o) begin
                    m_valid = 1;
                    m_val   = res;
                    m_ovf   = (res == MAX);
                end else begin
                    m_drop = 1;
                end
            end else if (m_valid && o) begin
                m_valid = 0;
            end
            m_prev = c;
        end
        m_cyc++;
    endtask

    task automatic tick(input bit r, input bit e, input bit c, input bit o);
        reset     = r;
        en        = e;
        comp_in   = c;
        out_ready = o;
        @(posedge clk);
        model_step(r, e, c, o);
        #1;
        check("val",       32'(val),       32'(m_val));
        check("val_valid", 32'(val_valid), 32'(m_valid));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("drop_err",  32'(drop_err),  32'(m_drop));
        check("busy",      32'(busy),      32'(m_meas));
        if (val_valid === 1'b1) begin
            valid_seen++;
            last_val = int'(val);
        end
    endtask

    initial begin
        // Reset state
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 1);
        check("rst_val", 32'(val), 32'd0);
        check("rst_valid", 32'(val_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Basic decode: edges 25 cycles apart, valid for exactly one cycle
        tick(1, 0, 0, 0);
        valid_seen = 0;
        for (int i = 0; i <= 40; i++) begin
            tick(0, 1, (i == 10 || i == 35), 1);
            if (i == 35) begin
                check("basic_val", 32'(val), 32'd25);
                check("basic_valid", 32'(val_valid), 32'd1);
                check("basic_ovf", 32'(overflow), 32'd0);
            end
        end
        check("basic_once", 32'(valid_seen), 32'd1);

        // Saturation: edges 300 cycles apart
        tick(1, 0, 0, 0);
        for (int i = 0; i <= 302; i++) begin
            tick(0, 1, (i == 0 || i == 300), 1);
            if (i == 300) begin
                check("sat_val", 32'(val), 32'd127);
                check("sat_ovf", 32'(overflow), 32'd1);
            end
        end

        // Back-pressure: second result lost, then consumer drains the slot
        tick(1, 0, 0, 0);
        for (int i = 0; i <= 12; i++) begin
            tick(0, 1, (i == 0 || i == 5 || i == 9), 0);
            if (i == 9) begin
                check("bp_val", 32'(val), 32'd5);
                check("bp_drop", 32'(drop_err), 32'd1);
            end
        end
        tick(0, 1, 0, 1);
        check("bp_drain", 32'(val_valid), 32'd0);

        // Transfer and load in the same cycle
        tick(1, 0, 0, 0);
        for (int i = 0; i <= 11; i++) begin
            tick(0, 1, (i == 0 || i == 8 || i == 11), (i == 11));
            if (i == 10) check("sim_hold", 32'(val), 32'd8);
        end
        check("sim_val", 32'(val), 32'd3);
        check("sim_valid", 32'(val_valid), 32'd1);
        check("sim_drop", 32'(drop_err), 32'd0);

        // Enable abort discards the partial interval
        tick(1, 0, 0, 0);
        valid_seen = 0;
        for (int i = 0; i <= 20; i++) begin
            tick(0, !(i == 4 || i == 5), (i == 0 || i == 10 || i == 17), 1);
        end
        check("abort_once", 32'(valid_seen), 32'd1);
        check("abort_val", 32'(last_val), 32'd7);

        // Reset with a pending result and a long partial count
        tick(1, 0, 0, 0);
        for (int i = 0; i <= 59; i++) begin
            tick(0, 1, (i == 0 || i == 10), 0);
        end
        tick(1, 1, 1, 1);
        check("mid_rst_val", 32'(val), 32'd0);
        check("mid_rst_valid", 32'(val_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i <= 25; i++) begin
            tick(0, 1, (i == 3 || i == 23), 1);
        end
        check("post_rst_val", 32'(last_val), 32'd20);

        // Held level counts once; 1,0,1 pulse train gives 2
        tick(1, 0, 0, 0);
        for (int i = 0; i <= 14; i++) begin
            tick(0, 1, (i <= 4 || i == 12 || i == 14), 1);
            if (i == 12) check("held_val", 32'(val), 32'd12);
            if (i == 14) check("train_val", 32'(val), 32'd2);
        end

        // Level held high across en 0->1 is not an edge
        tick(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, (i >= 3), 1, 1);
        check("en_hold_busy", 32'(busy), 32'd0);
        for (int i = 0; i <= 8; i++) tick(0, 1, (i == 2 || i == 6), 1);
        check("en_hold_val", 32'(last_val), 32'd4);

        // Randomized: short intervals with back-pressure and occasional reset/disable
        for (int i = 0; i < 2500; i++) begin
            tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
        end
        // Randomized: sparse edges to reach saturation
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 1499) == 0), ($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 119) == 0), ($urandom_range(0, 1) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_interval_decoder.md
PULSE_INTERVAL_DECODER -- requirements
Module: pulse_interval_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7: bit width of the measured interval and of val.
REQ-002 The block SHALL have port counter_clk, input, 1: single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1: measurement enable.
REQ-005 The block SHALL have port comp_in, input, 1: comparator pulse stream to decode; synchronous to counter_clk.
REQ-006 The block SHALL have port out_ready, input, 1: consumer accepts val this cycle.
REQ-007 The block SHALL have port val, output, WIDTH: decoded interval in counter_clk cycles.
REQ-008 The block SHALL have port val_valid, output, 1: val holds an unconsumed result.
REQ-009 The block SHALL have port overflow, output, 1: the result in val saturated; qualified by val_valid.
REQ-010 The block SHALL have port drop_err, output, 1: sticky flag set when a result was lost.
REQ-011 The block SHALL have port busy, output, 1: high in state COUNT.

Function
REQ-012 The block SHALL register comp_in each cycle into comp_q.
REQ-013 The block SHALL define edge = comp_in AND NOT comp_q, evaluated only when en=1.
REQ-014 The block SHALL implement FSM states IDLE and COUNT.
REQ-015 IDLE SHALL go to COUNT on edge and set cnt to 1; otherwise the FSM stays in IDLE with cnt held at 0.
REQ-016 In COUNT without edge, cnt SHALL increment by 1, saturating at 2^WIDTH-1; there SHALL be no wrap-around.
REQ-017 In COUNT with edge, the block SHALL produce result = cnt, set result overflow to 1 if cnt = 2^WIDTH-1, reload cnt to 1, and stay in COUNT.
REQ-018 Consequently, two rising edges N cycles apart SHALL yield val = min(N, 2^WIDTH-1).
REQ-019 A produced result SHALL appear on val, overflow and val_valid on the clock after the edge cycle (latency 1).
REQ-020 Transfer SHALL occur when val_valid=1 and out_ready=1; val_valid SHALL clear the next cycle unless a new result is loaded in the same cycle.
REQ-021 A result SHALL load if val_valid=0, or if val_valid=1 and out_ready=1 in the same cycle; in the latter case val_valid stays 1 with the new value.
REQ-022 If val_valid=1 and out_ready=0 when a result is produced, the new result SHALL be discarded, the old val, overflow and val_valid SHALL be held unchanged, and drop_err SHALL set to 1.
REQ-023 val and overflow SHALL be stable while val_valid=1 and no transfer occurs.
REQ-024 en=0 SHALL force the FSM to IDLE and cnt to 0 on the next clock, abandoning any partial interval.
REQ-025 en=0 SHALL NOT clear a pending val/val_valid; the consumer may still take it.
REQ-026 comp_q SHALL update regardless of en, so a comp_in held high across en 0->1 produces no edge.
REQ-027 A comp_in held high for multiple cycles SHALL count as one edge; a 1-cycle-spaced pulse train (1,0,1) SHALL give val=2.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set FSM=IDLE, cnt=0, comp_q=0, val=0, val_valid=0, overflow=0, drop_err=0, busy=0.
REQ-029 Reset SHALL take priority over en, comp_in and out_ready.
REQ-030 Reset mid-COUNT or with a pending result SHALL discard both.
REQ-031 drop_err SHALL clear only on reset.

Verification
REQ-032 Bench SHALL check basic decode: en=1, out_ready=1, comp_in edges at cycles 10 and 35 -> val=25, overflow=0, val_valid high for exactly 1 cycle at cycle 36.
REQ-033 Bench SHALL check saturation: edges 300 cycles apart, WIDTH=7 -> val=127, overflow=1.
REQ-034 Bench SHALL check back-pressure and drop: out_ready=0, edges at 0, 5 and 9 -> val=5 held; second result (4) discarded; drop_err=1; then out_ready=1 -> val_valid drops the next cycle.
REQ-035 Bench SHALL check simultaneous transfer and load: val_valid=1 holding val=8, out_ready=1 in the same cycle as a new edge with cnt=3 -> next cycle val=3, val_valid=1, drop_err=0.
REQ-036 Bench SHALL check enable abort: edge at 0, en=0 at cycle 4, en=1 at cycle 6, edges at 10 and 17 -> only one result, val=7; no result from the aborted interval.
REQ-037 Bench SHALL check reset mid-operation: reset during COUNT with cnt=50 and a pending val -> all outputs 0 next cycle; the first interval measured after reset is exact.
